// File: rtl/music_sequencer_multi_pkg.sv
// Shared types and default widths for the multi-voice music sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package music_pkg;

    localparam int NUM_CH_DEF   = 2;
    localparam int TICK_W_DEF   = 16;
    localparam int PERIOD_W_DEF = 16;
    localparam int DUR_W_DEF    = 12;
    localparam int DEPTH_DEF    = 32;

    // One note-table entry: half-period in clk cycles (0 = rest), duration in ms (0 = end marker)
    typedef struct packed {
        logic [PERIOD_W_DEF-1:0] period;
        logic [DUR_W_DEF-1:0]    dur;
    } note_t;

    // Global sequencer state
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } seq_state_e;

    // Per-voice phase: READ presents a new index to the RAM, LOAD consumes the read data
    typedef enum logic [2:0] {
        CH_OFF,
        CH_READ,
        CH_LOAD,
        CH_NOTE,
        CH_DONE
    } ch_state_e;

endpackage

// File: rtl/music_sequencer_multi_tone_channel.sv
// One voice: walks its note table, counts note length in ms ticks and generates the square wave.
// Latency: RAM data is consumed in the load cycle; first rising edge comes P cycles after that load cycle.
// Backpressure: none; free-runs on ms_tick_i and raises finished_o once its sequence ends.
module tone_channel
    import music_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                go_i,
    input  logic                ms_tick_i,
    input  logic                loop_en_i,
    input  logic [PERIOD_W-1:0] rd_period_i,
    input  logic [DUR_W-1:0]    rd_dur_i,
    output logic [IDX_W-1:0]    rd_addr_o,
    output logic                sound_o,
    output logic                finished_o
);

    ch_state_e           ph_q, ph_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] tone_q, tone_d;
    logic                snd_q, snd_d;

    // Next-state: sequencing through the table, duration countdown and tone toggling
    always_comb begin
        ph_d   = ph_q;
        idx_d  = idx_q;
        dur_d  = dur_q;
        per_d  = per_q;
        tone_d = tone_q;
        snd_d  = snd_q;
        if (clr_i) begin
            ph_d   = CH_OFF;
            idx_d  = '0;
            dur_d  = '0;
            per_d  = '0;
            tone_d = '0;
            snd_d  = 1'b0;
        end else if (go_i) begin
            // global LOAD cycle reads index 0; its data arrives next cycle
            ph_d  = CH_LOAD;
            idx_d = '0;
            snd_d = 1'b0;
        end else begin
            unique case (ph_q)
                CH_READ: ph_d = CH_LOAD;
                CH_LOAD: begin
                    tone_d = '0;
                    snd_d  = 1'b0;
                    if (rd_dur_i == '0) begin
                        // an end marker at index 0 can never loop, so it always finishes
                        if (idx_q != '0 && loop_en_i) begin
                            idx_d = '0;
                            ph_d  = CH_READ;
                        end else begin
                            ph_d = CH_DONE;
                        end
                    end else begin
                        per_d = rd_period_i;
                        dur_d = rd_dur_i;
                        ph_d  = CH_NOTE;
                        // the load cycle itself is the first low cycle of the half-period
                        if (rd_period_i == PERIOD_W'(1)) begin
                            snd_d = 1'b1;
                        end else if (rd_period_i != '0) begin
                            tone_d = PERIOD_W'(1);
                        end
                    end
                end
                CH_NOTE: begin
                    if (per_q != '0) begin
                        if (tone_q == per_q - PERIOD_W'(1)) begin
                            tone_d = '0;
                            snd_d  = ~snd_q;
                        end else begin
                            tone_d = tone_q + PERIOD_W'(1);
                        end
                    end
                    if (ms_tick_i) begin
                        if (dur_q == DUR_W'(1)) begin
                            snd_d  = 1'b0;
                            tone_d = '0;
                            if (idx_q == IDX_W'(DEPTH - 1)) begin
                                if (loop_en_i) begin
                                    idx_d = '0;
                                    ph_d  = CH_READ;
                                end else begin
                                    ph_d = CH_DONE;
                                end
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                                ph_d  = CH_READ;
                            end
                        end else begin
                            dur_d = dur_q - DUR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q   <= CH_OFF;
            idx_q  <= '0;
            dur_q  <= '0;
            per_q  <= '0;
            tone_q <= '0;
            snd_q  <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            idx_q  <= idx_d;
            dur_q  <= dur_d;
            per_q  <= per_d;
            tone_q <= tone_d;
            snd_q  <= snd_d;
        end
    end

    assign rd_addr_o  = idx_q;
    assign sound_o    = snd_q;
    assign finished_o = (ph_q == CH_DONE);

endmodule

// File: rtl/music_sequencer_multi.sv
// Multi-voice note sequencer: per-channel note RAMs, ms divider, global FSM, sigma-delta mixer, LED status.
// Latency: start at cycle t -> LOAD at t+1, PLAY at t+2, first sound rise at t+2+P.
// Backpressure: none; table writes are accepted in every state.
module music_sequencer_multi
    import music_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int TICK_W   = TICK_W_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TICK_W-1:0]   ticks_per_milli,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [DUR_W-1:0]    wr_dur,
    output logic [NUM_CH-1:0]   sound,
    output logic                mix,
    output logic                busy,
    output logic                done,
    output logic [7:0]          led
);

    localparam int ENT_W = PERIOD_W + DUR_W;
    localparam int ACC_W = $clog2(NUM_CH) + 1;
    localparam int LED_W = (IDX_W < 7) ? IDX_W : 7;

    seq_state_e        state_q, state_d;
    logic              seq_clr;
    logic              ms_tick;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d, tick_lim;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W:0]    pop, sum;
    logic              mix_q, mix_d;
    logic [NUM_CH-1:0] snd, fin;
    logic [IDX_W-1:0]  ch_idx [NUM_CH];

    // Global FSM next state; stop outranks start, both clear every voice
    always_comb begin
        state_d = state_q;
        seq_clr = 1'b0;
        done    = 1'b0;
        if (stop) begin
            state_d = IDLE;
            seq_clr = 1'b1;
        end else if (start) begin
            state_d = LOAD;
            seq_clr = 1'b1;
        end else begin
            unique case (state_q)
                LOAD: state_d = PLAY;
                PLAY: begin
                    if (&fin) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Global FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign busy = (state_q != IDLE);

    // ms divider: 0 and 1 both mean one cycle per ms; the limit is re-read every cycle
    always_comb begin
        tick_lim = (ticks_per_milli == '0) ? '0 : ticks_per_milli - TICK_W'(1);
        ms_tick  = busy && (tick_cnt_q == tick_lim);
        if (seq_clr)      tick_cnt_d = '0;
        else if (!busy)   tick_cnt_d = tick_cnt_q;
        else if (ms_tick) tick_cnt_d = '0;
        else              tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end

    // ms divider register
    always_ff @(posedge clk) begin
        if (rst) tick_cnt_q <= '0;
        else     tick_cnt_q <= tick_cnt_d;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ENT_W-1:0] ram_q [DEPTH];
        logic [ENT_W-1:0] rd_q;

        // Note table: demuxed write port and synchronous read of the voice's current index
        always_ff @(posedge clk) begin
            if (wr_en && wr_ch == CH_W'(c)) ram_q[wr_addr] <= {wr_period, wr_dur};
            rd_q <= ram_q[ch_idx[c]];
        end

        tone_channel #(
            .PERIOD_W (PERIOD_W),
            .DUR_W    (DUR_W),
            .DEPTH    (DEPTH)
        ) u_voice (
            .clk         (clk),
            .rst         (rst),
            .clr_i       (seq_clr),
            .go_i        (state_q == LOAD),
            .ms_tick_i   (ms_tick),
            .loop_en_i   (loop_en),
            .rd_period_i (rd_q[ENT_W-1:DUR_W]),
            .rd_dur_i    (rd_q[DUR_W-1:0]),
            .rd_addr_o   (ch_idx[c]),
            .sound_o     (snd[c]),
            .finished_o  (fin[c])
        );
    end

    // First-order sigma-delta: density of mix equals average fraction of voices high
    always_comb begin
        pop = '0;
        for (int c = 0; c < NUM_CH; c++) pop = pop + (ACC_W+1)'(snd[c]);
        sum = {1'b0, acc_q} + pop;
        if (sum >= (ACC_W+1)'(NUM_CH)) begin
            mix_d = 1'b1;
            acc_d = ACC_W'(sum - (ACC_W+1)'(NUM_CH));
        end else begin
            mix_d = 1'b0;
            acc_d = ACC_W'(sum);
        end
        if (stop) begin
            mix_d = 1'b0;
            acc_d = '0;
        end
    end

    // Mixer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            mix_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            mix_q <= mix_d;
        end
    end

    assign sound = snd;
    assign mix   = mix_q;
    assign led   = {busy, 7'(ch_idx[0][LED_W-1:0])};

endmodule

// File: tb/tb_music_sequencer_multi.sv
// Directed self-checking bench for music_sequencer_multi with two voices.
// Inputs are driven and outputs sampled on the falling clock edge.
// Cycle k counts cycles after the edge that sampled start (k=1 is the LOAD cycle).
module tb_music_sequencer_multi;
    import music_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ticks_per_milli;
    logic        start, stop, loop_en, wr_en;
    logic [0:0]  wr_ch;
    logic [4:0]  wr_addr;
    logic [15:0] wr_period;
    logic [11:0] wr_dur;
    logic [1:0]  sound;
    logic        mix, busy, done;
    logic [7:0]  led;

    int tests_run    = 0;
    int tests_failed = 0;

    music_sequencer_multi #(
        .NUM_CH(2), .TICK_W(16), .PERIOD_W(16), .DUR_W(12), .DEPTH(32)
    ) dut (
        .clk(clk), .rst(rst), .ticks_per_milli(ticks_per_milli),
        .start(start), .stop(stop), .loop_en(loop_en),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_period(wr_period), .wr_dur(wr_dur),
        .sound(sound), .mix(mix), .busy(busy), .done(done), .led(led)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic write_note(input int ch, input int addr, input int per, input int dur);
        note_t n;
        n.period = 16'(per);
        n.dur    = 12'(dur);
        @(negedge clk);
        wr_en = 1'b1; wr_ch = 1'(ch); wr_addr = 5'(addr);
        wr_period = n.period; wr_dur = n.dur;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Leaves the bench at the falling edge inside cycle k=1
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (sound !== 2'b00) begin tests_failed++; $display("FAIL reset_sound got %b exp 00", sound); end
        tests_run++; if (mix !== 1'b0)    begin tests_failed++; $display("FAIL reset_mix got %b exp 0", mix); end
        tests_run++; if (busy !== 1'b0)   begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests_run++; if (done !== 1'b0)   begin tests_failed++; $display("FAIL reset_done got %b exp 0", done); end
        tests_run++; if (led !== 8'h00)   begin tests_failed++; $display("FAIL reset_led got %h exp 00", led); end
        rst = 1'b0;
    endtask

    // ch0 {P=3,dur=2},{end}; 4 clk per ms: ticks at k=4,8; sound high k=5..7; done at k=11
    task automatic test_single_note();
        logic [12:0] exp_snd;
        exp_snd = 13'h0E0;
        ticks_per_milli = 16'd4;
        loop_en = 1'b0;
        write_note(0, 0, 3, 2);
        write_note(0, 1, 0, 0);
        write_note(1, 0, 0, 0);
        pulse_start();
        for (int k = 1; k <= 12; k++) begin
            tests_run++; if (sound[0] !== exp_snd[k]) begin tests_failed++; $display("FAIL t1_sound k=%0d got %b exp %b", k, sound[0], exp_snd[k]); end
            tests_run++; if (done !== (k == 11))      begin tests_failed++; $display("FAIL t1_done k=%0d got %b exp %b", k, done, (k == 11)); end
            tests_run++; if (busy !== (k <= 11))      begin tests_failed++; $display("FAIL t1_busy k=%0d got %b exp %b", k, busy, (k <= 11)); end
            if (k == 1) begin
                tests_run++; if (led !== 8'h80) begin tests_failed++; $display("FAIL t1_led_k1 got %h exp 80", led); end
            end
            if (k == 9) begin
                tests_run++; if (led !== 8'h81) begin tests_failed++; $display("FAIL t1_led_k9 got %h exp 81", led); end
            end
            @(negedge clk);
        end
    endtask

    // ticks_per_milli 0 and 1: one ms per cycle; ch0 {P=1,dur=2}: high at k=3, done at k=7
    task automatic test_tick_zero_one();
        write_note(0, 0, 1, 2);
        write_note(0, 1, 0, 0);
        for (int r = 0; r < 2; r++) begin
            ticks_per_milli = 16'(r);
            pulse_start();
            for (int k = 1; k <= 10; k++) begin
                tests_run++; if (sound[0] !== (k == 3)) begin tests_failed++; $display("FAIL t2_sound tpm=%0d k=%0d got %b exp %b", r, k, sound[0], (k == 3)); end
                tests_run++; if (done !== (k == 7))     begin tests_failed++; $display("FAIL t2_done tpm=%0d k=%0d got %b exp %b", r, k, done, (k == 7)); end
                tests_run++; if (busy !== (k <= 7))     begin tests_failed++; $display("FAIL t2_busy tpm=%0d k=%0d got %b exp %b", r, k, busy, (k <= 7)); end
                @(negedge clk);
            end
        end
    endtask

    // Looping {P=2,dur=1},{end} at 2 clk/ms: one high cycle every 6, at k=4,10,..,64; then stop
    task automatic test_loop_stop();
        int highs;
        int dones;
        highs = 0;
        dones = 0;
        ticks_per_milli = 16'd2;
        loop_en = 1'b1;
        write_note(0, 0, 2, 1);
        write_note(0, 1, 0, 0);
        pulse_start();
        for (int k = 1; k <= 64; k++) begin
            if (sound[0] === 1'b1) highs++;
            if (done !== 1'b0) dones++;
            if (k == 64) begin
                tests_run++; if (sound[0] !== 1'b1) begin tests_failed++; $display("FAIL t3_sound_k64 got %b exp 1", sound[0]); end
                stop = 1'b1;
            end
            @(negedge clk);
        end
        stop = 1'b0;
        if (done !== 1'b0) dones++;
        tests_run++; if (highs !== 11)     begin tests_failed++; $display("FAIL t3_high_cycles got %0d exp 11", highs); end
        tests_run++; if (sound !== 2'b00)  begin tests_failed++; $display("FAIL t3_sound_after_stop got %b exp 00", sound); end
        tests_run++; if (busy !== 1'b0)    begin tests_failed++; $display("FAIL t3_busy_after_stop got %b exp 0", busy); end
        tests_run++; if (dones !== 0)      begin tests_failed++; $display("FAIL t3_done_pulses got %0d exp 0", dones); end
        loop_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ch0 {P=1,dur=3}, ch1 {rest,dur=1} at 10 clk/ms: ch0 toggles k=3..30, done at k=33
    task automatic test_two_voice();
        int snd1_highs;
        int dones;
        int done_k;
        int mix_highs;
        snd1_highs = 0; dones = 0; done_k = -1; mix_highs = 0;
        ticks_per_milli = 16'd10;
        loop_en = 1'b0;
        write_note(0, 0, 1, 3);
        write_note(0, 1, 0, 0);
        write_note(1, 0, 0, 1);
        write_note(1, 1, 0, 0);
        pulse_start();
        for (int k = 1; k <= 40; k++) begin
            if (sound[1] !== 1'b0) snd1_highs++;
            if (done === 1'b1) begin dones++; done_k = k; end
            if (k >= 8 && k <= 23 && mix === 1'b1) mix_highs++;
            if (k == 3) begin
                tests_run++; if (sound[0] !== 1'b1) begin tests_failed++; $display("FAIL t4_sound0_k3 got %b exp 1", sound[0]); end
            end
            if (k == 34) begin
                tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL t4_busy_k34 got %b exp 0", busy); end
            end
            @(negedge clk);
        end
        tests_run++; if (snd1_highs !== 0) begin tests_failed++; $display("FAIL t4_rest_sound1 got %0d high cycles exp 0", snd1_highs); end
        tests_run++; if (dones !== 1)      begin tests_failed++; $display("FAIL t4_done_count got %0d exp 1", dones); end
        tests_run++; if (done_k !== 33)    begin tests_failed++; $display("FAIL t4_done_cycle got %0d exp 33", done_k); end
        tests_run++; if (mix_highs !== 4)  begin tests_failed++; $display("FAIL t4_mix_density got %0d of 16 exp 4", mix_highs); end
    endtask

    // Restart in the middle of a note replays from scratch
    task automatic test_back_to_back();
        logic [12:0] exp_snd;
        exp_snd = 13'h0E0;
        ticks_per_milli = 16'd4;
        write_note(0, 0, 3, 2);
        write_note(0, 1, 0, 0);
        pulse_start();
        for (int k = 1; k < 6; k++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tests_run++; if (sound[0] !== exp_snd[k]) begin tests_failed++; $display("FAIL t7_sound k=%0d got %b exp %b", k, sound[0], exp_snd[k]); end
            tests_run++; if (done !== (k == 11))      begin tests_failed++; $display("FAIL t7_done k=%0d got %b exp %b", k, done, (k == 11)); end
            @(negedge clk);
        end
    endtask

    // Reset in PLAY, then replay from the retained table
    task automatic test_reset_mid_play();
        logic [12:0] exp_snd;
        exp_snd = 13'h0E0;
        ticks_per_milli = 16'd4;
        write_note(0, 0, 3, 2);
        write_note(0, 1, 0, 0);
        pulse_start();
        for (int k = 1; k <= 7; k++) begin
            tests_run++; if (sound[0] !== exp_snd[k]) begin tests_failed++; $display("FAIL t6_first_sound k=%0d got %b exp %b", k, sound[0], exp_snd[k]); end
            if (k < 7) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++; if (sound !== 2'b00) begin tests_failed++; $display("FAIL t6_rst_sound got %b exp 00", sound); end
        tests_run++; if (mix !== 1'b0)    begin tests_failed++; $display("FAIL t6_rst_mix got %b exp 0", mix); end
        tests_run++; if (busy !== 1'b0)   begin tests_failed++; $display("FAIL t6_rst_busy got %b exp 0", busy); end
        tests_run++; if (done !== 1'b0)   begin tests_failed++; $display("FAIL t6_rst_done got %b exp 0", done); end
        tests_run++; if (led !== 8'h00)   begin tests_failed++; $display("FAIL t6_rst_led got %h exp 00", led); end
        rst = 1'b0;
        pulse_start();
        for (int k = 1; k <= 12; k++) begin
            tests_run++; if (sound[0] !== exp_snd[k]) begin tests_failed++; $display("FAIL t6_replay_sound k=%0d got %b exp %b", k, sound[0], exp_snd[k]); end
            tests_run++; if (done !== (k == 11))      begin tests_failed++; $display("FAIL t6_replay_done k=%0d got %b exp %b", k, done, (k == 11)); end
            @(negedge clk);
        end
    endtask

    // Index 0 is an end marker on both voices with looping on: done at k=3, idle at k=4
    task automatic test_end_marker_first();
        int dones;
        int done_k;
        dones = 0; done_k = -1;
        ticks_per_milli = 16'd4;
        loop_en = 1'b1;
        write_note(0, 0, 0, 0);
        write_note(1, 0, 0, 0);
        pulse_start();
        for (int k = 1; k <= 8; k++) begin
            if (done === 1'b1) begin dones++; done_k = k; end
            if (k == 4) begin
                tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL t5_busy_k4 got %b exp 0", busy); end
            end
            @(negedge clk);
        end
        tests_run++; if (done_k !== 3) begin tests_failed++; $display("FAIL t5_done_cycle got %0d exp 3", done_k); end
        tests_run++; if (dones !== 1)  begin tests_failed++; $display("FAIL t5_done_count got %0d exp 1", dones); end
        loop_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ticks_per_milli = 16'd4;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        wr_en = 1'b0; wr_ch = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0;
        test_reset();
        test_single_note();
        test_tick_zero_one();
        test_loop_stop();
        test_two_voice();
        test_back_to_back();
        test_reset_mid_play();
        test_end_marker_first();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
